// File: rtl/control_sequencer_imm.sv
// -----------------------------------------------------------------------------
// control_sequencer_imm
//
// Hardwired Moore control unit for the Datapath. It sequences the three-step
// fetch (T0..T2) and the immediate-format instructions addi, andi, ori and ldi
// (T3..T5). It also handles halt and the Stop request. Every control strobe is
// decoded combinationally from the registered step. In T3..T5 the opcode in IR
// also takes part, so an asynchronous Reset drops all strobes at once.
//
// Ports
//   Clock        in   1   rising-edge clock
//   Reset        in   1   asynchronous, active-high; forces S_RST
//   IR           in  32   instruction register; opcode is IR[31:27]
//   Stop         in   1   halt request, honoured only at an instruction boundary
//   PCout .. Cout out  1   Datapath control strobes
//   alu_op       out  5   ALU operation select, non-zero only in T4
//   Run          out  1   high while sequencing, low in S_RST and S_HALT
//   instr_count  out 16   retired-instruction counter, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module control_sequencer_imm #(
    parameter logic [4:0] OP_ADDI = 5'b01100,
    parameter logic [4:0] OP_ANDI = 5'b01101,
    parameter logic [4:0] OP_ORI  = 5'b01110,
    parameter logic [4:0] OP_LDI  = 5'b00001,
    parameter logic [4:0] OP_HALT = 5'b11011,
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter logic [4:0] ALU_AND = 5'b00101,
    parameter logic [4:0] ALU_OR  = 5'b00110
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_instr_count;
    logic        w_retire;
    logic [4:0]  w_opcode;
    logic        w_is_alu_imm;
    logic        w_unused_ir;

    // The operand fields are used by the Datapath, not by this sequencer.
    assign w_opcode     = IR[31:27];
    assign w_unused_ir  = ^IR[26:0];
    assign w_is_alu_imm = (w_opcode == OP_ADDI) || (w_opcode == OP_ANDI) ||
                          (w_opcode == OP_ORI);

    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every flop samples values from before the edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_RST;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire)
                r_instr_count <= r_instr_count + 16'd1;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        PCout    = 1'b0;  Zlowout = 1'b0;  Zhighout = 1'b0;  MDRout = 1'b0;
        MARin    = 1'b0;  Zin     = 1'b0;  PCin     = 1'b0;  MDRin  = 1'b0;
        IRin     = 1'b0;  Yin     = 1'b0;  IncPC    = 1'b0;  Read   = 1'b0;
        Write    = 1'b0;  CONin   = 1'b0;  Gra      = 1'b0;  Grb    = 1'b0;
        Grc      = 1'b0;  Rin     = 1'b0;  Rout     = 1'b0;  BAout  = 1'b0;
        Cout     = 1'b0;
        alu_op   = 5'b00000;
        Run      = 1'b1;

        unique case (r_state)
            S_RST: begin
                Run          = 1'b0;
                w_next_state = S_T0;
            end
            S_T0: begin
                PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  Zin = 1'b1;
                w_next_state = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;  PCin = 1'b1;  Read = 1'b1;  MDRin = 1'b1;
                w_next_state = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1;  IRin = 1'b1;
                w_next_state = S_T3;
            end
            S_T3: begin
                if (w_is_alu_imm) begin
                    Grb = 1'b1;  Rout = 1'b1;  Yin = 1'b1;
                    w_next_state = S_T4;
                end else if (w_opcode == OP_LDI) begin
                    // ldi uses Rb == R0, so BAout puts zero on the bus.
                    Grb = 1'b1;  BAout = 1'b1;  Yin = 1'b1;
                    w_next_state = S_T4;
                end else if (w_opcode == OP_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    // An unsupported opcode retires as a NOP. That is an
                    // instruction boundary, so Stop is sampled here.
                    w_retire     = 1'b1;
                    w_next_state = Stop ? S_HALT : S_T0;
                end
            end
            S_T4: begin
                Cout = 1'b1;  Zin = 1'b1;
                if (w_opcode == OP_ANDI)
                    alu_op = ALU_AND;
                else if (w_opcode == OP_ORI)
                    alu_op = ALU_OR;
                else
                    alu_op = ALU_ADD;
                w_next_state = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
                w_retire     = 1'b1;
                w_next_state = Stop ? S_HALT : S_T0;
            end
            S_HALT: begin
                Run          = 1'b0;
                w_next_state = S_HALT;
            end
            default: begin
                Run          = 1'b0;
                w_next_state = S_RST;
            end
        endcase
    end

    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_control_sequencer_imm.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer_imm
//
// Directed bench for control_sequencer_imm. The 21 strobes are packed into one
// vector, in port order. Each step's expected vector is built from named bits.
// Inputs change 1 ns after a rising edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_control_sequencer_imm;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
    logic        IRin, Yin, IncPC, Read, Write, CONin, Gra, Grb, Grc, Rin;
    logic        Rout, BAout, Cout;
    logic [4:0]  alu_op;
    logic        Run;
    logic [15:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe bit positions inside the packed vector (MSB = PCout).
    localparam logic [20:0] B_PCOUT   = 21'h1 << 20;
    localparam logic [20:0] B_ZLOWOUT = 21'h1 << 19;
    localparam logic [20:0] B_MDROUT  = 21'h1 << 17;
    localparam logic [20:0] B_MARIN   = 21'h1 << 16;
    localparam logic [20:0] B_ZIN     = 21'h1 << 15;
    localparam logic [20:0] B_PCIN    = 21'h1 << 14;
    localparam logic [20:0] B_MDRIN   = 21'h1 << 13;
    localparam logic [20:0] B_IRIN    = 21'h1 << 12;
    localparam logic [20:0] B_YIN     = 21'h1 << 11;
    localparam logic [20:0] B_INCPC   = 21'h1 << 10;
    localparam logic [20:0] B_READ    = 21'h1 << 9;
    localparam logic [20:0] B_GRA     = 21'h1 << 6;
    localparam logic [20:0] B_GRB     = 21'h1 << 5;
    localparam logic [20:0] B_RIN     = 21'h1 << 3;
    localparam logic [20:0] B_ROUT    = 21'h1 << 2;
    localparam logic [20:0] B_BAOUT   = 21'h1 << 1;
    localparam logic [20:0] B_COUT    = 21'h1 << 0;

    localparam logic [20:0] E_NONE = 21'h0;
    localparam logic [20:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [20:0] E_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [20:0] E_T2   = B_MDROUT | B_IRIN;
    localparam logic [20:0] E_T3R  = B_GRB | B_ROUT | B_YIN;
    localparam logic [20:0] E_T3L  = B_GRB | B_BAOUT | B_YIN;
    localparam logic [20:0] E_T4   = B_COUT | B_ZIN;
    localparam logic [20:0] E_T5   = B_ZLOWOUT | B_GRA | B_RIN;

    // Instructions: op[31:27], Ra[26:23], Rb[22:19], C[18:0].
    localparam logic [31:0] I_ADDI = {5'b01100, 4'd2, 4'd1, 19'd5};
    localparam logic [31:0] I_ANDI = {5'b01101, 4'd3, 4'd2, 19'h0F};
    localparam logic [31:0] I_ORI  = {5'b01110, 4'd4, 4'd3, 19'h30};
    localparam logic [31:0] I_LDI  = {5'b00001, 4'd5, 4'd0, 19'd7};
    localparam logic [31:0] I_NOP  = {5'b10000, 27'd0};
    localparam logic [31:0] I_HALT = {5'b11011, 27'd0};

    logic [20:0] strobes;
    assign strobes = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
                      IRin, Yin, IncPC, Read, Write, CONin, Gra, Grb, Grc, Rin,
                      Rout, BAout, Cout};

    control_sequencer_imm dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .IncPC(IncPC), .Read(Read), .Write(Write), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .alu_op(alu_op), .Run(Run), .instr_count(instr_count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Checks the strobes, alu_op and Run for the current step.
    task automatic expect_step(input string tag, input logic [20:0] s,
                               input logic [4:0] op, input logic run);
        check({tag, ".strobes"}, {11'd0, strobes}, {11'd0, s});
        check({tag, ".alu_op"},  {27'd0, alu_op},  {27'd0, op});
        check({tag, ".run"},     {31'd0, Run},     {31'd0, run});
    endtask

    // Advances from T0 through T2 and checks the fetch strobes.
    task automatic fetch(input string tag);
        step(); expect_step({tag, ".T1"}, E_T1, 5'd0, 1'b1);
        step(); expect_step({tag, ".T2"}, E_T2, 5'd0, 1'b1);
    endtask

    // Runs one immediate instruction starting in T0 and ends back in T0.
    task automatic run_imm(input string tag, input logic [31:0] instr,
                           input logic [20:0] t3, input logic [4:0] op,
                           input logic [15:0] cnt_after);
        IR = instr;
        fetch(tag);
        step(); expect_step({tag, ".T3"}, t3,   5'd0, 1'b1);
        step(); expect_step({tag, ".T4"}, E_T4, op,   1'b1);
        step(); expect_step({tag, ".T5"}, E_T5, 5'd0, 1'b1);
        step(); expect_step({tag, ".T0"}, E_T0, 5'd0, 1'b1);
        check({tag, ".count"}, {16'd0, instr_count}, {16'd0, cnt_after});
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("reset.async_strobes", {11'd0, strobes}, 32'd0);
        check("reset.async_count", {16'd0, instr_count}, 32'd0);
        step();
        Reset = 1'b0;
        step();
        expect_step("reset.T0", E_T0, 5'd0, 1'b1);
    endtask

    initial begin
        Reset = 1'b1;
        Stop  = 1'b0;
        IR    = 32'd0;

        // 1. Reset held three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            expect_step("rst.hold", E_NONE, 5'd0, 1'b0);
            check("rst.count", {16'd0, instr_count}, 32'd0);
        end
        Reset = 1'b0;
        check("rst.srst_run", {31'd0, Run}, 32'd0);
        step(); expect_step("boot.T0", E_T0, 5'd0, 1'b1);

        // 2-4. addi, andi and ori back to back, then ldi.
        run_imm("addi", I_ADDI, E_T3R, 5'b00011, 16'd1);
        run_imm("andi", I_ANDI, E_T3R, 5'b00101, 16'd2);
        run_imm("ori",  I_ORI,  E_T3R, 5'b00110, 16'd3);
        run_imm("ldi",  I_LDI,  E_T3L, 5'b00011, 16'd4);

        // An unsupported opcode retires as a NOP after T3.
        IR = I_NOP;
        fetch("nop");
        step(); expect_step("nop.T3", E_NONE, 5'd0, 1'b1);
        step(); expect_step("nop.T0", E_T0, 5'd0, 1'b1);
        check("nop.count", {16'd0, instr_count}, 32'd5);

        // 5b. halt opcode: S_HALT and the count does not change.
        IR = I_HALT;
        fetch("halt");
        step(); expect_step("halt.T3", E_NONE, 5'd0, 1'b1);
        step(); expect_step("halt.stay0", E_NONE, 5'd0, 1'b0);
        check("halt.count", {16'd0, instr_count}, 32'd5);
        step(); expect_step("halt.stay1", E_NONE, 5'd0, 1'b0);

        // 5a. Stop is raised in T2 of addi. addi still completes, then S_HALT.
        do_reset();
        IR = I_ADDI;
        step(); expect_step("stop.T1", E_T1, 5'd0, 1'b1);
        step(); expect_step("stop.T2", E_T2, 5'd0, 1'b1);
        Stop = 1'b1;
        step(); expect_step("stop.T3", E_T3R, 5'd0, 1'b1);
        step(); expect_step("stop.T4", E_T4, 5'b00011, 1'b1);
        step(); expect_step("stop.T5", E_T5, 5'd0, 1'b1);
        step(); expect_step("stop.halt", E_NONE, 5'd0, 1'b0);
        check("stop.count", {16'd0, instr_count}, 32'd1);
        Stop = 1'b0;
        step(); expect_step("stop.stay", E_NONE, 5'd0, 1'b0);

        // 6. Reset asserted mid-T4 clears the outputs before the next edge.
        do_reset();
        run_imm("pre", I_ADDI, E_T3R, 5'b00011, 16'd1);
        IR = I_ANDI;
        fetch("mid");
        step(); expect_step("mid.T3", E_T3R, 5'd0, 1'b1);
        step(); expect_step("mid.T4", E_T4, 5'b00101, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        expect_step("mid.async", E_NONE, 5'd0, 1'b0);
        check("mid.count", {16'd0, instr_count}, 32'd0);
        step();
        Reset = 1'b0;
        step(); expect_step("mid.recover", E_T0, 5'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
